// File: rtl/ram_master_pkg.sv
// ram_master shared types: FSM state encoding and default widths.
// FIFO count width helper used by the top and the read FIFO.
package ram_master_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_LEN_WIDTH  = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_CNT_WIDTH = cnt_width(DEF_FIFO_DEPTH);

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO holding read bytes for ram_master.
// Power-of-two depth; pointers wrap naturally, count is one bit wider.
module sync_fifo
  import ram_master_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int CW = cnt_width(FIFO_DEPTH),
  localparam int PW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  always_comb begin
    wr_d  = wr_q + PW'(do_push);
    rd_d  = rd_q + PW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/ram_master.sv
// Burst initiator for the single-port synchronous ram (1-cycle read).
// RAM_MASTER_WRAP_CHECK_EN: reject bursts crossing the top address.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam int LW = LEN_WIDTH + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [LW-1:0]         rem_q, rem_d;
  logic                  pend_q, pend_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          cmd_fire;
  logic          wr_fire;
  logic          issue;
  logic          credit_ok;
  logic          last;
  logic          wrap_hit;

`ifdef RAM_MASTER_WRAP_CHECK_EN
  logic [ADDR_WIDTH+LEN_WIDTH:0] end_addr;
  logic                          err_q, err_d;

  assign end_addr = (ADDR_WIDTH+LEN_WIDTH+1)'(cmd_addr)
                  + (ADDR_WIDTH+LEN_WIDTH+1)'(cmd_len);
  assign wrap_hit = |end_addr[ADDR_WIDTH+LEN_WIDTH:ADDR_WIDTH];
  assign err      = (state_q == S_DONE) && err_q;
`else
  assign wrap_hit = 1'b0;
  assign err      = 1'b0;
`endif

  // Reads in flight plus buffered bytes never exceed the FIFO size
  assign credit_ok = ((CW+1)'(fifo_count) + (CW+1)'(pend_q))
                   < (CW+1)'(FIFO_DEPTH) && !fifo_full;

  assign cmd_ready = (state_q == S_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wr_ready  = (state_q == S_WRITE);
  assign wr_fire   = wr_ready && wr_valid;
  assign issue     = (state_q == S_READ) && credit_ok;
  assign last      = (rem_q == LW'(1));

  assign mem_we    = wr_fire && !rst;
  assign mem_addr  = ptr_q;
  assign mem_din   = wr_data;
  assign done      = (state_q == S_DONE);
  assign rd_valid  = !fifo_empty;
  assign fifo_pop  = rd_valid && rd_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    pend_d  = issue;
`ifdef RAM_MASTER_WRAP_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          ptr_d = cmd_addr;
          rem_d = LW'(cmd_len) + LW'(1);
`ifdef RAM_MASTER_WRAP_CHECK_EN
          err_d = wrap_hit;
`endif
          if (wrap_hit)       state_d = S_DONE;
          else if (cmd_write) state_d = S_WRITE;
          else                state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (wr_fire) begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
          rem_d = rem_q - LW'(1);
          if (last) state_d = S_DONE;
        end
      end
      S_READ: begin
        if (issue) begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
          rem_d = rem_q - LW'(1);
          if (last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!pend_q && fifo_empty) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      pend_q  <= 1'b0;
`ifdef RAM_MASTER_WRAP_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
`ifdef RAM_MASTER_WRAP_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // mem_dout belongs to the read issued one cycle earlier
  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (pend_q),
    .din  (mem_dout),
    .pop  (fifo_pop),
    .dout (rd_data),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: doc/ram_master.md
Name: ram_master

Overview:
- Burst initiator for the single-port synchronous `ram` block: drives its `we`/`addr`/`din` port and collects `dout`.
- Accepts one command at a time from the CPU side:
  - Write burst: consumes a write-data stream and stores consecutive bytes.
  - Read burst: fetches consecutive bytes into a small FIFO and presents them on a read stream with backpressure.
- Handles the RAM's one-cycle registered read latency internally.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 8, RAM address width.
- LEN_WIDTH, 4, burst-length field width; burst length = cmd_len+1 (1..16).
- FIFO_DEPTH, 4, read-data FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both valid and ready are high.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  LEN_WIDTH  burst length minus 1.
- wr_valid  in  1  write byte offered.
- wr_ready  out  1  write byte consumed.
- wr_data  in  DATA_WIDTH  write byte.
- rd_valid  out  1  read byte available.
- rd_ready  in  1  read byte consumed.
- rd_data  out  DATA_WIDTH  read byte (FIFO head).
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  valid with done; 1 = command rejected.
- mem_we  out  1  to ram `we`.
- mem_addr  out  ADDR_WIDTH  to ram `addr`.
- mem_din  out  DATA_WIDTH  to ram `din`.
- mem_dout  in  DATA_WIDTH  from ram `dout`.

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE; FIFO and pending flag are flushed; address pointer and remaining count clear to 0.
  - Reset values: cmd_ready=1, wr_ready=0, rd_valid=0, done=0, err=0, mem_we=0, mem_addr=0.
  - mem_we is gated with !rst, so no RAM write occurs on a reset edge.
  - Reset mid-burst abandons the burst silently: no done pulse, and RAM contents already written stay written.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch ptr=cmd_addr and remaining=cmd_len+1 (LEN_WIDTH+1 bits).
  - Next state is WRITE if cmd_write=1, else READ.
- WRITE:
  - wr_ready=1; mem_we=wr_valid; mem_addr=ptr; mem_din=wr_data (all combinational).
  - Each accepted byte: ptr+1, remaining-1.
  - When the last byte is accepted, go to DONE.
  - wr_valid low inserts an idle cycle with mem_we=0.
- READ:
  - Issues a read (mem_addr=ptr, mem_we=0) when fifo_count + pending < FIFO_DEPTH.
  - Each issue sets pending, ptr+1, remaining-1.
  - The cycle after an issue, mem_dout is pushed into the FIFO (push at the end of that cycle); pending is cleared unless a new issue occurs in the same cycle.
  - After the last issue, go to DRAIN.
  - With rd_ready held high, throughput is one byte per cycle.
  - First rd_valid appears two cycles after the first issue cycle.
- DRAIN:
  - Waits for pending=0 and FIFO empty, then goes to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - cmd_ready=0 throughout WRITE, READ, DRAIN and DONE.
- Read stream:
  - rd_valid = FIFO non-empty; rd_data = head.
  - A pop occurs on rd_valid & rd_ready.
  - A simultaneous push and pop in one cycle keeps the count unchanged.
  - The credit rule guarantees a push never occurs into a full FIFO.
- Address arithmetic:
  - ptr increments modulo 2^ADDR_WIDTH; 0xFF+1 wraps to 0x00 (when the optional feature is compiled out).
- mem_addr holds ptr in IDLE/DRAIN/DONE; mem_we=0 in every state other than WRITE.

Optional Feature:
- Macro RAM_MASTER_WRAP_CHECK_EN.
- Defined:
  - A command with cmd_addr + cmd_len > 2^ADDR_WIDTH-1 is accepted but goes straight to DONE with err=1.
  - No RAM access occurs and no wr_data is consumed.
- Undefined:
  - The address wraps to 0 and err is tied to 0.

Decomposition:
- Package ram_master_pkg:
  - State enum (IDLE, WRITE, READ, DRAIN, DONE).
  - Default width constants.
  - Derived FIFO count width, $clog2(FIFO_DEPTH)+1.
- One sub-module, sync_fifo:
  - Parameterized DATA_WIDTH/FIFO_DEPTH.
  - push/pop, count, full, empty.
  - Synchronous active-high reset.

Test Plan:
- Write burst: cmd_write=1, addr=0x10, len=3, wr_data 0xA1,0xA2,0xA3,0xA4 with wr_valid=1 → mem_we high 4 consecutive cycles at 0x10..0x13; done pulse one cycle later; RAM model holds A1..A4.
- Read-back: read addr=0x10, len=3, rd_ready=1 → rd_data A1,A2,A3,A4 on 4 consecutive cycles, first one 2 cycles after the first issue; done after the last pop.
- Backpressure: read len=15 with rd_ready=0 for 10 cycles → at most FIFO_DEPTH issues; no data lost or reordered when rd_ready rises.
- Wrap: addr=0xFE, len=3 →
  - With the macro undefined: RAM accesses at FE,FF,00,01.
  - With RAM_MASTER_WRAP_CHECK_EN defined: done with err=1, no mem_we and no wr_ready activity.
- Write stalls: wr_valid toggling 1,0,1,0 → mem_we follows wr_valid; addresses stay consecutive.
- Reset mid-read: rst asserted during READ with 2 bytes in the FIFO → next cycle rd_valid=0, cmd_ready=1, no done; a new command then completes normally.
